// File: rtl/ks_adder_arbiter_if.sv
// Operand, result, adder and utilisation signals of the two-requester adder arbiter.
// The arbiter attaches through the slave modport; requesters plus the adder sit on master.
interface ks_adder_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
);
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;

    logic              resp0_valid;
    logic              resp0_ready;
    logic              resp1_valid;
    logic              resp1_ready;
    logic [DATA_W:0]   resp_sum;

    logic [DATA_W-1:0] add_a;
    logic [DATA_W-1:0] add_b;
    logic [DATA_W:0]   add_sum;

    logic [CNT_W-1:0]  grant_cnt0;
    logic [CNT_W-1:0]  grant_cnt1;

    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
        input  resp0_ready, resp1_ready, add_sum,
        output req0_ready, req1_ready, resp0_valid, resp1_valid, resp_sum,
        output add_a, add_b, grant_cnt0, grant_cnt1
    );

    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
        output resp0_ready, resp1_ready, add_sum,
        input  req0_ready, req1_ready, resp0_valid, resp1_valid, resp_sum,
        input  add_a, add_b, grant_cnt0, grant_cnt1
    );
endinterface

// File: rtl/ks_adder_arbiter.sv
// Round-robin arbiter time-sharing one external approximate adder between two requesters.
// One operation in flight at a time: IDLE accepts, EXEC lets the adder settle, HOLD returns the sum.
module ks_adder_arbiter #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    ks_adder_arbiter_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

    state_t            state_reg;
    logic              last_reg;
    logic              gid_reg;
    logic [DATA_W-1:0] add_a_reg;
    logic [DATA_W-1:0] add_b_reg;
    logic [DATA_W:0]   resp_sum_reg;
    logic [1:0]        resp_valid_reg;
    logic [CNT_W-1:0]  grant_cnt_reg [2];

    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0]        accept;
    logic [1:0]        resp_ready;
    logic [DATA_W-1:0] req_a [2];
    logic [DATA_W-1:0] req_b [2];
    logic              win_idx;

    assign req_valid  = {bus.req1_valid, bus.req0_valid};
    assign resp_ready = {bus.resp1_ready, bus.resp0_ready};
    assign req_a[0]   = bus.req0_a;
    assign req_a[1]   = bus.req1_a;
    assign req_b[0]   = bus.req0_b;
    assign req_b[1]   = bus.req1_b;

    // Accepts are mutually exclusive, so bit 1 alone identifies the winner.
    assign accept  = req_valid & req_ready;
    assign win_idx = accept[1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            // On a tie, the requester that was not served last gets the slot.
            assign req_ready[gi] = (state_reg == IDLE) && req_valid[gi] &&
                                   (!req_valid[1-gi] || (last_reg != 1'(gi)));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    grant_cnt_reg[gi] <= '0;
                end else if (accept[gi]) begin
                    grant_cnt_reg[gi] <= grant_cnt_reg[gi] + CNT_W'(1);
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            last_reg       <= 1'b1;
            gid_reg        <= 1'b0;
            add_a_reg      <= '0;
            add_b_reg      <= '0;
            resp_sum_reg   <= '0;
            resp_valid_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|accept) begin
                        add_a_reg <= req_a[win_idx];
                        add_b_reg <= req_b[win_idx];
                        gid_reg   <= win_idx;
                        last_reg  <= win_idx;
                        state_reg <= EXEC;
                    end
                end
                EXEC: begin
                    // The adder has had a full period on the registered operands.
                    resp_sum_reg            <= bus.add_sum;
                    resp_valid_reg[gid_reg] <= 1'b1;
                    state_reg               <= HOLD;
                end
                HOLD: begin
                    if (resp_ready[gid_reg]) begin
                        resp_valid_reg <= '0;
                        state_reg      <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.req0_ready  = req_ready[0];
    assign bus.req1_ready  = req_ready[1];
    assign bus.resp0_valid = resp_valid_reg[0];
    assign bus.resp1_valid = resp_valid_reg[1];
    assign bus.resp_sum    = resp_sum_reg;
    assign bus.add_a       = add_a_reg;
    assign bus.add_b       = add_b_reg;
    assign bus.grant_cnt0  = grant_cnt_reg[0];
    assign bus.grant_cnt1  = grant_cnt_reg[1];
endmodule
